// File: rtl/sprite_pixel_mapper.sv
// Sprite pixel mapper: sprite-box coordinate + animation state -> RGB.
// Three-stage pipeline with frame-boundary attribute latching.
module sprite_pixel_mapper #(
    parameter int SPRITE_W   = 100,
    parameter int SPRITE_H   = 120,
    parameter int ADDR_W     = 19,
    parameter int NUM_FRAMES = 19,
    parameter int FRAME_W    = 5,
    parameter int STATE_W    = 6,
    parameter int CODE_W     = 4,
    parameter int NUM_PAL    = 2,
    parameter int PAL_W      = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [STATE_W-1:0] anim_state,
    input  logic               flip,
    input  logic [PAL_W-1:0]   pal_sel,
    input  logic               in_valid,
    input  logic [9:0]         px,
    input  logic [9:0]         py,
    input  logic               map_we,
    input  logic [STATE_W-1:0] map_state,
    input  logic [FRAME_W-1:0] map_frame,
    input  logic               pal_we,
    input  logic [PAL_W-1:0]   pal_wsel,
    input  logic [CODE_W-1:0]  pal_widx,
    input  logic [23:0]        pal_wdata,
    output logic [FRAME_W-1:0] rom_frame,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [CODE_W-1:0]  rom_code,
    output logic               out_valid,
    output logic [7:0]         Red,
    output logic [7:0]         Green,
    output logic [7:0]         Blue,
    output logic               zero
);

    localparam int          CODES = 1 << CODE_W;
    localparam int          MAP_N = 1 << STATE_W;
    localparam logic [31:0] SW_U  = 32'(SPRITE_W);
    localparam logic [31:0] SH_U  = 32'(SPRITE_H);
    localparam logic [31:0] NF_U  = 32'(NUM_FRAMES);
    localparam logic [31:0] NP_U  = 32'(NUM_PAL);

    function automatic logic [23:0] pal_default(input int idx);
        case (idx % 16)
            0:       return 24'h80b8a8;
            1:       return 24'hf0b000;
            2:       return 24'hf0e079;
            3:       return 24'hf0da9a;
            4:       return 24'hf0c080;
            5:       return 24'hbf744f;
            6:       return 24'h101010;
            7:       return 24'h440403;
            8:       return 24'hf34700;
            9:       return 24'hd84000;
            10:      return 24'hb03000;
            11:      return 24'h6d3829;
            12:      return 24'hf84800;
            13:      return 24'hcc885c;
            14:      return 24'hf0f0f0;
            default: return 24'h584048;
        endcase
    endfunction

    logic [FRAME_W-1:0] map_q [MAP_N];
    logic [23:0]        pal_q [NUM_PAL][CODES];

    logic [FRAME_W-1:0] act_frame_q;
    logic               act_flip_q;
    logic [PAL_W-1:0]   act_pal_q;

    logic               v1_q;
    logic               box1_q;
    logic [PAL_W-1:0]   pal1_q;
    logic [FRAME_W-1:0] rom_frame_q;
    logic [ADDR_W-1:0]  rom_addr_q;

    logic               v2_q;
    logic               box2_q;
    logic [PAL_W-1:0]   pal2_q;

    logic               out_valid_q;
    logic [23:0]        rgb_q;
    logic               zero_q;

    logic               in_box_d;
    logic [31:0]        xe_d;
    logic [ADDR_W-1:0]  rom_addr_d;
    logic [PAL_W-1:0]   pal_sel_d;
    logic [FRAME_W-1:0] map_wdata_d;
    logic               pal_wok_d;
    logic               transp_d;
    logic [23:0]        rgb_d;

    // Address generation, input sanitising and final colour lookup
    always_comb begin
        in_box_d    = (32'(px) < SW_U) && (32'(py) < SH_U);
        xe_d        = act_flip_q ? (SW_U - 32'd1 - 32'(px)) : 32'(px);
        rom_addr_d  = ADDR_W'(32'(py) * SW_U + xe_d);
        pal_sel_d   = (32'(pal_sel) < NP_U) ? pal_sel : '0;
        map_wdata_d = (32'(map_frame) < NF_U) ? map_frame : '0;
        pal_wok_d   = 32'(pal_wsel) < NP_U;
        transp_d    = !box2_q || (rom_code == '0);
        rgb_d       = transp_d ? 24'hffffff : pal_q[pal2_q][rom_code];
    end

    // Programmable animation-state to frame-ROM map
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int s = 0; s < MAP_N; s++) begin
                map_q[s] <= FRAME_W'(s % NUM_FRAMES);
            end
        end else if (map_we) begin
            map_q[map_state] <= map_wdata_d;
        end
    end

    // Writable palettes; reads in the same cycle see the pre-write entry
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++) begin
                for (int c = 0; c < CODES; c++) begin
                    pal_q[p][c] <= pal_default(c);
                end
            end
        end else if (pal_we && pal_wok_d) begin
            pal_q[pal_wsel][pal_widx] <= pal_wdata;
        end
    end

    // Active attributes change only at frame boundaries to avoid tearing
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_frame_q <= '0;
            act_flip_q  <= 1'b0;
            act_pal_q   <= '0;
        end else if (frame_start) begin
            act_frame_q <= map_q[anim_state];
            act_flip_q  <= flip;
            act_pal_q   <= pal_sel_d;
        end
    end

    // Stage 1: issue ROM address for the requested pixel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q        <= 1'b0;
            box1_q      <= 1'b0;
            pal1_q      <= '0;
            rom_frame_q <= '0;
            rom_addr_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                box1_q      <= in_box_d;
                pal1_q      <= act_pal_q;
                rom_frame_q <= act_frame_q;
                rom_addr_q  <= rom_addr_d;
            end
        end
    end

    // Stage 2: carry pixel tags alongside the synchronous ROM read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v2_q   <= 1'b0;
            box2_q <= 1'b0;
            pal2_q <= '0;
        end else begin
            v2_q   <= v1_q;
            box2_q <= box1_q;
            pal2_q <= pal1_q;
        end
    end

    // Stage 3: registered colour output, held between valid pixels
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            rgb_q       <= '0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                rgb_q  <= rgb_d;
                zero_q <= transp_d;
            end
        end
    end

    assign rom_frame = rom_frame_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = out_valid_q;
    assign Red       = rgb_q[23:16];
    assign Green     = rgb_q[15:8];
    assign Blue      = rgb_q[7:0];
    assign zero      = zero_q;

endmodule

// File: tb/tb_sprite_pixel_mapper.sv
// Bench for sprite_pixel_mapper: vector table, corner sequences
// and a randomized run against a behavioural model.
module tb_sprite_pixel_mapper;

    localparam int SW = 100;
    localparam int SH = 120;
    localparam int AMOD = 1 << 19;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic [5:0]  anim_state;
    logic        flip;
    logic [0:0]  pal_sel;
    logic        in_valid;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        map_we;
    logic [5:0]  map_state;
    logic [4:0]  map_frame;
    logic        pal_we;
    logic [0:0]  pal_wsel;
    logic [3:0]  pal_widx;
    logic [23:0] pal_wdata;
    logic [4:0]  rom_frame;
    logic [18:0] rom_addr;
    logic [3:0]  rom_code = 4'd0;
    logic        out_valid;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        zero;

    int checks = 0;
    int errors = 0;
    int rom_force = -1;

    always #5 Clk = ~Clk;

    sprite_pixel_mapper dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .anim_state(anim_state), .flip(flip), .pal_sel(pal_sel),
        .in_valid(in_valid), .px(px), .py(py),
        .map_we(map_we), .map_state(map_state), .map_frame(map_frame),
        .pal_we(pal_we), .pal_wsel(pal_wsel), .pal_widx(pal_widx),
        .pal_wdata(pal_wdata), .rom_frame(rom_frame), .rom_addr(rom_addr),
        .rom_code(rom_code), .out_valid(out_valid),
        .Red(Red), .Green(Green), .Blue(Blue), .zero(zero)
    );

    localparam logic [23:0] DEF_PAL [16] = '{
        24'h80b8a8, 24'hf0b000, 24'hf0e079, 24'hf0da9a,
        24'hf0c080, 24'hbf744f, 24'h101010, 24'h440403,
        24'hf34700, 24'hd84000, 24'hb03000, 24'h6d3829,
        24'hf84800, 24'hcc885c, 24'hf0f0f0, 24'h584048};

    // Frame ROM contents (test fixture), synchronous read
    function automatic logic [3:0] rom_fn(input int f, input int a);
        int t;
        t = (a ^ (a >> 5)) + f * 3;
        return 4'(t & 15);
    endfunction

    always @(posedge Clk)
        rom_code <= (rom_force >= 0) ? 4'(rom_force)
                                     : rom_fn(int'(rom_frame), int'(rom_addr));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, Red, Green, Blue};
    endfunction

    task automatic idle();
        frame_start = 0; anim_state = 0; flip = 0; pal_sel = 0;
        in_valid = 0; px = 0; py = 0;
        map_we = 0; map_state = 0; map_frame = 0;
        pal_we = 0; pal_wsel = 0; pal_widx = 0; pal_wdata = 0;
    endtask

    task automatic latch(input int st, input bit fl, input int ps);
        frame_start = 1; anim_state = 6'(st); flip = fl; pal_sel = 1'(ps);
        step();
        frame_start = 0;
    endtask

    // Issue one pixel; returns at the cycle its result is visible
    task automatic do_pixel(input int x, input int y);
        in_valid = 1; px = 10'(x); py = 10'(y);
        step();
        in_valid = 0;
        step();
        step();
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        int frame;
        int addr;
        bit box;
        int pal;
    } pix_t;

    int          m_map [64];
    logic [23:0] m_pal [2][16];
    int          m_frame, m_flip, m_palsel;
    pix_t        m_q [$];
    bit          e_valid;
    logic [23:0] e_rgb;
    bit          e_zero;
    int          e_frame, e_addr;

    task automatic model_reset();
        for (int s = 0; s < 64; s++) m_map[s] = s % 19;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 16; c++) m_pal[p][c] = DEF_PAL[c];
        m_frame = 0; m_flip = 0; m_palsel = 0;
        m_q.delete();
        e_valid = 0; e_rgb = 0; e_zero = 1; e_frame = 0; e_addr = 0;
    endtask

    task automatic model_edge();
        pix_t p, n;
        int x, code;
        if (m_q.size() == 2) begin
            p = m_q.pop_front();
            e_valid = p.v;
            if (p.v) begin
                code = int'(rom_fn(p.frame, p.addr));
                if (!p.box || code == 0) begin
                    e_rgb = 24'hffffff; e_zero = 1;
                end else begin
                    e_rgb = m_pal[p.pal][code]; e_zero = 0;
                end
            end
        end else begin
            e_valid = 0;
        end
        x = m_flip != 0 ? SW - 1 - int'(px) : int'(px);
        n.v = in_valid;
        n.addr = ((int'(py) * SW + x) % AMOD + AMOD) % AMOD;
        n.box = (int'(px) < SW) && (int'(py) < SH);
        n.frame = m_frame;
        n.pal = m_palsel;
        m_q.push_back(n);
        if (in_valid) begin
            e_frame = n.frame; e_addr = n.addr;
        end
        if (frame_start) begin
            m_frame = m_map[anim_state];
            m_flip = int'(flip);
            m_palsel = int'(pal_sel) < 2 ? int'(pal_sel) : 0;
        end
        if (map_we) m_map[map_state] = int'(map_frame) < 19 ? int'(map_frame) : 0;
        if (pal_we && int'(pal_wsel) < 2) m_pal[pal_wsel][pal_widx] = pal_wdata;
    endtask

    task automatic randomize_inputs();
        frame_start = ($urandom_range(0, 9) == 0);
        anim_state  = 6'($urandom_range(0, 63));
        flip        = 1'($urandom_range(0, 1));
        pal_sel     = 1'($urandom_range(0, 1));
        in_valid    = ($urandom_range(0, 9) < 7);
        px          = 10'($urandom_range(0, 110));
        py          = 10'($urandom_range(0, 125));
        map_we      = ($urandom_range(0, 9) == 0);
        map_state   = 6'($urandom_range(0, 63));
        map_frame   = 5'($urandom_range(0, 31));
        pal_we      = ($urandom_range(0, 9) == 0);
        pal_wsel    = 1'($urandom_range(0, 1));
        pal_widx    = 4'($urandom_range(0, 15));
        pal_wdata   = 24'($urandom);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          st;
        bit          fl;
        int          ps;
        int          x;
        int          y;
        int          code;
        int          ef;
        int          ea;
        bit          ez;
        logic [23:0] ergb;
    } vec_t;

    localparam int NV = 8;
    vec_t vt [NV];

    initial begin
        vt[0] = '{2,  1'b0, 0, 3,   1,   1,  2, 103,   1'b0, 24'hf0b000};
        vt[1] = '{0,  1'b1, 0, 0,   0,   5,  0, 99,    1'b0, 24'hbf744f};
        vt[2] = '{0,  1'b1, 0, 99,  0,   14, 0, 0,     1'b0, 24'hf0f0f0};
        vt[3] = '{0,  1'b0, 0, 10,  10,  0,  0, 1010,  1'b1, 24'hffffff};
        vt[4] = '{0,  1'b0, 0, 100, 0,   3,  0, 100,   1'b1, 24'hffffff};
        vt[5] = '{0,  1'b0, 0, 0,   120, 2,  0, 12000, 1'b1, 24'hffffff};
        vt[6] = '{25, 1'b0, 0, 99,  119, 15, 6, 11999, 1'b0, 24'h584048};
        vt[7] = '{40, 1'b0, 1, 5,   2,   8,  2, 205,   1'b0, 24'hf34700};

        idle();
        Reset_n = 0;
        step(); step();
        chk("rst_frame", 32'(rom_frame), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_rgb", rgb(), 0);
        chk("rst_zero", 32'(zero), 1);
        Reset_n = 1;
        step();

        for (int i = 0; i < NV; i++) begin
            latch(vt[i].st, vt[i].fl, vt[i].ps);
            rom_force = vt[i].code;
            in_valid = 1; px = 10'(vt[i].x); py = 10'(vt[i].y);
            step();
            in_valid = 0;
            chk($sformatf("vec%0d_frame", i), 32'(rom_frame), 32'(vt[i].ef));
            chk($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(vt[i].ea));
            step();
            chk($sformatf("vec%0d_early", i), 32'(out_valid), 0);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_rgb", i), rgb(), 32'(vt[i].ergb));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vt[i].ez));
        end

        // palette write, then lookup racing a second write
        pal_we = 1; pal_wsel = 1; pal_widx = 1; pal_wdata = 24'h123456;
        latch(2, 0, 1);
        pal_we = 0;
        rom_force = 1;
        do_pixel(3, 1);
        chk("pal_new", rgb(), 32'h123456);
        in_valid = 1; px = 3; py = 1;
        step();
        in_valid = 0;
        step();
        pal_we = 1; pal_wsel = 1; pal_widx = 1; pal_wdata = 24'habcdef;
        step();
        pal_we = 0;
        chk("pal_same_edge", rgb(), 32'h123456);
        do_pixel(3, 1);
        chk("pal_after", rgb(), 32'habcdef);

        // frame map writes and latch timing
        map_we = 1; map_state = 20; map_frame = 7;
        step();
        map_we = 0; anim_state = 20;
        do_pixel(0, 0);
        chk("map_no_latch", 32'(rom_frame), 2);
        latch(20, 0, 0);
        do_pixel(0, 0);
        chk("map_latched", 32'(rom_frame), 7);
        map_we = 1; map_state = 21; map_frame = 9;
        latch(21, 0, 0);
        map_we = 0;
        do_pixel(0, 0);
        chk("map_same_edge", 32'(rom_frame), 2);
        latch(21, 0, 0);
        do_pixel(0, 0);
        chk("map_new", 32'(rom_frame), 9);
        map_we = 1; map_state = 22; map_frame = 25;
        step();
        map_we = 0;
        latch(22, 0, 0);
        do_pixel(0, 0);
        chk("map_clamp", 32'(rom_frame), 0);

        // reset in the middle of a back-to-back stream
        latch(2, 0, 0);
        rom_force = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; px = 10'(i); py = 0;
            if (i == 5) begin
                chk("stream_valid", 32'(out_valid), 1);
                #2;
                Reset_n = 0;
                #1;
                chk("rst_mid_valid", 32'(out_valid), 0);
                chk("rst_mid_zero", 32'(zero), 1);
                chk("rst_mid_addr", 32'(rom_addr), 0);
            end
            step();
            if (i >= 5) chk($sformatf("rst_hold%0d", i), 32'(out_valid), 0);
        end
        in_valid = 0;
        Reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_quiet%0d", i), 32'(out_valid), 0);
        end
        in_valid = 1; px = 3; py = 1;
        step();
        in_valid = 0;
        chk("rst_lat1", 32'(out_valid), 0);
        chk("rst_addr2", 32'(rom_addr), 103);
        step();
        chk("rst_lat2", 32'(out_valid), 0);
        step();
        chk("rst_lat3", 32'(out_valid), 1);
        chk("rst_rgb2", rgb(), 32'hf0b000);

        // randomized run against the model
        rom_force = -1;
        idle();
        Reset_n = 0;
        step(); step();
        model_reset();
        Reset_n = 1;
        randomize_inputs();
        for (int c = 0; c < 500; c++) begin
            step();
            model_edge();
            chk($sformatf("rnd%0d_valid", c), 32'(out_valid), 32'(e_valid));
            chk($sformatf("rnd%0d_rgb", c), rgb(), 32'(e_rgb));
            chk($sformatf("rnd%0d_zero", c), 32'(zero), 32'(e_zero));
            chk($sformatf("rnd%0d_addr", c), 32'(rom_addr), 32'(e_addr));
            chk($sformatf("rnd%0d_frame", c), 32'(rom_frame), 32'(e_frame));
            randomize_inputs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
